vdp_cpu_port: RTL

CPU-side port block for the video display processor: decodes the data and control I/O ports and owns the VDP register file and VRAM address pointer. It provides the read-ahead buffer, status register, interrupt flag and a VRAM request/acknowledge handshake. It sits between the tv80n I/O bus and the video block's VRAM port. It generalises the TMS9918 port scheme to wider VRAM addresses and larger register files, such as V9938-class parts.

---
 rtl/vdp_cpu_port.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: TMS9918-style CPU I/O port with register file, VRAM pointer,
// read-ahead buffer, status flags and a VRAM request/acknowledge handshake.
module vdp_cpu_port #(
    parameter int ADDR_W = 14,
    parameter int NUM_REGS = 8,
    parameter logic [7:0] BASE_PORT = 8'h98
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic [7:0]            io_addr,
    input  logic                  io_rd_n,
    input  logic                  io_wr_n,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  wait_n,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [7:0]            vram_wdata,
    output logic                  vram_we,
    output logic                  vram_re,
    input  logic [7:0]            vram_rdata,
    input  logic                  vram_ack,
    output logic [NUM_REGS*8-1:0] regs,
    input  logic                  frame_set,
    input  logic                  coll_set,
    input  logic                  fifth_set,
    input  logic [4:0]            fifth_num,
    output logic                  irq_n
);
    typedef enum logic [1:0] {IDLE, WREQ, RREQ} state_t;
    state_t state_q, state_d;
    logic wr_n_q, rd_n_q, rd_dsel_q, rd_csel_q, sbf_q;
    logic f_q, c_q, s5_q, irq_n_q, pend_q, pend_w_q;
    logic [4:0] s5num_q;
    logic [7:0] latch_q, buffer_q, wdata_q, pend_data_q;
    logic [ADDR_W-1:0] ptr_q, addr_q, ptr_set, base;
    logic [NUM_REGS*8-1:0] regs_q;
    logic dsel, csel, dwr, cwr, drd, srd, setup, rnew, can_issue, iss_w, iss_r;
    logic [7:0] r14, wdata;

    assign dsel = io_addr == BASE_PORT;
    assign csel = io_addr == BASE_PORT + 8'd1;
    // writes act on the leading strobe edge, reads on the trailing one
    assign dwr = clk_en && !io_wr_n && wr_n_q && dsel;
    assign cwr = clk_en && !io_wr_n && wr_n_q && csel;
    assign drd = clk_en && io_rd_n && !rd_n_q && rd_dsel_q;
    assign srd = clk_en && io_rd_n && !rd_n_q && rd_csel_q;
    assign setup = cwr && sbf_q && !din[7];
    assign rnew = drd || (setup && !din[6]);
    assign can_issue = state_q == IDLE || vram_ack;
    assign r14 = (NUM_REGS > 14) ? regs_q[8*((NUM_REGS > 14) ? 14 : 0) +: 8] : 8'd0;
    assign ptr_set = ADDR_W'({r14, din[5:0], latch_q});
    assign base = setup ? ptr_set : ptr_q;

    assign dout = (dsel && !io_rd_n) ? buffer_q :
                  (csel && !io_rd_n) ? {f_q, s5_q, c_q, s5num_q} : 8'hFF;
    assign wait_n = !(pend_q || (state_q != IDLE && dsel && !io_rd_n));
    assign vram_addr = addr_q;
    assign vram_wdata = wdata_q;
    assign vram_we = state_q == WREQ;
    assign vram_re = state_q == RREQ;
    assign regs = regs_q;
    assign irq_n = irq_n_q;

    // a stalled access is replayed first, ahead of any new request
    always_comb begin
        iss_w = 1'b0;
        iss_r = 1'b0;
        wdata = din;
        if (pend_q && can_issue) begin
            iss_w = pend_w_q;
            iss_r = !pend_w_q;
            wdata = pend_data_q;
        end else if (can_issue) begin
            iss_w = dwr;
            iss_r = rnew && !dwr;
        end
        state_d = iss_w ? WREQ : iss_r ? RREQ : vram_ack ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            rd_dsel_q   <= 1'b0;
            rd_csel_q   <= 1'b0;
            sbf_q       <= 1'b0;
            latch_q     <= 8'd0;
            buffer_q    <= 8'd0;
            wdata_q     <= 8'd0;
            pend_q      <= 1'b0;
            pend_w_q    <= 1'b0;
            pend_data_q <= 8'd0;
            ptr_q       <= '0;
            addr_q      <= '0;
            regs_q      <= '0;
            f_q         <= 1'b0;
            c_q         <= 1'b0;
            s5_q        <= 1'b0;
            s5num_q     <= 5'd0;
            irq_n_q     <= 1'b1;
        end else begin
            if (clk_en) begin
                wr_n_q <= io_wr_n;
                rd_n_q <= io_rd_n;
            end
            if (clk_en && !io_rd_n) begin
                rd_dsel_q <= dsel;
                rd_csel_q <= csel;
            end
            if (cwr && !sbf_q) latch_q <= din;
            sbf_q <= cwr ? !sbf_q : (dwr || drd || srd) ? 1'b0 : sbf_q;
            for (int i = 0; i < NUM_REGS; i++)
                if (cwr && sbf_q && din[7] && din[5:0] == 6'(i)) regs_q[8*i +: 8] <= latch_q;
            if (iss_w || iss_r) begin
                addr_q <= base;
                ptr_q  <= base + ADDR_W'(1);
            end else if (setup) ptr_q <= base;
            if (state_q == RREQ && vram_ack) buffer_q <= vram_rdata;
            if (iss_w) begin
                wdata_q  <= wdata;
                buffer_q <= wdata;
            end
            if (pend_q && can_issue) pend_q <= 1'b0;
            else if (!can_issue && (dwr || rnew)) begin
                pend_q      <= 1'b1;
                pend_w_q    <= dwr;
                pend_data_q <= din;
            end
            f_q  <= frame_set || (f_q && !srd);
            c_q  <= coll_set || (c_q && !srd);
            s5_q <= fifth_set || (s5_q && !srd);
            if (fifth_set && !s5_q) s5num_q <= fifth_num;
            irq_n_q <= !(f_q && regs_q[13]);
        end
    end
endmodule
